check_input_seq: RTL and testbench

//  Player-response checker; sits directly downstream of the sequence display stage.
//  On the display stage's done pulse it captures the current sequence and level, then

---
 rtl/game_pkg.sv | 30 +++
 rtl/check_input_seq_if.sv | 26 ++
 rtl/check_input_seq_timeout.sv | 28 ++
 rtl/check_input_seq.sv | 104 ++++++++++
 tb/tb_check_input_seq.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared constants for the memory-game datapath: sizes, FSM encodings and fail codes.
package game_pkg;

  localparam int NUM_DIGITS = 5;
  localparam int DIGIT_W    = 4;
  localparam int SEQ_W      = NUM_DIGITS * DIGIT_W;
  localparam int LVL_W      = 3;
  localparam int IDX_W      = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LISTEN = 2'd1;
  localparam logic [1:0] ST_PASS   = 2'd2;
  localparam logic [1:0] ST_FAIL   = 2'd3;

  typedef logic [1:0] fail_code_t;

  localparam fail_code_t FAIL_NONE    = 2'b00;
  localparam fail_code_t FAIL_WRONG   = 2'b01;
  localparam fail_code_t FAIL_TIMEOUT = 2'b10;

  // A level of 0 still checks one digit; anything past the sequence length is capped.
  function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] lvl);
    if (lvl == '0)
      return LVL_W'(1);
    else if (lvl > LVL_W'(NUM_DIGITS))
      return LVL_W'(NUM_DIGITS);
    return lvl;
  endfunction

endpackage

// File: rtl/check_input_seq_if.sv
// Round-control and keypad signals between the display stage, keypad, game controller and checker.
interface check_input_seq_if;
  import game_pkg::*;

  logic                 start;
  logic [LVL_W-1:0]     curLvl;
  logic [SEQ_W-1:0]     seq;
  logic                 keyValid;
  logic [DIGIT_W-1:0]   keyDigit;
  logic                 listening;
  logic [IDX_W-1:0]     digitIdx;
  logic                 lvlPass;
  logic                 lvlFail;
  fail_code_t           failCode;

  modport master (
    output start, curLvl, seq, keyValid, keyDigit,
    input  listening, digitIdx, lvlPass, lvlFail, failCode
  );

  modport slave (
    input  start, curLvl, seq, keyValid, keyDigit,
    output listening, digitIdx, lvlPass, lvlFail, failCode
  );

endinterface

// File: rtl/check_input_seq_timeout.sv
// Per-digit inactivity timer: saturating up-counter, expired while at TIMEOUT_CYC-1.
module input_timeout #(
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != CNT_LAST))
      count <= count + CNT_W'(1);
  end

  assign expired = (count == CNT_LAST);

endmodule

// File: rtl/check_input_seq.sv
// Player-response checker: latches the displayed sequence on start, then compares keypad
// digits one by one and reports a single-cycle pass or fail to the game controller.
//
// state     | meaning
// ST_IDLE   | waiting for start from the display stage; keys ignored
// ST_LISTEN | comparing keypad entries, inactivity timer running
// ST_PASS   | one-cycle lvlPass pulse
// ST_FAIL   | one-cycle lvlFail pulse, failCode holds the reason
module check_input_seq
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  check_input_seq_if.slave   bus
);

  logic [1:0]         state;
  logic [SEQ_W-1:0]   seq_lat;
  logic [LVL_W-1:0]   lvl_lat;
  logic [IDX_W-1:0]   digit_idx;
  fail_code_t         fail_code;

  logic [DIGIT_W-1:0] exp_digit;
  logic               key_match;
  logic               last_digit;
  logic               timer_clear;
  logic               timer_en;
  logic               timer_expired;

  // Digit 0 sits in the most significant nibble of the sequence.
  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i))
        exp_digit = seq_lat[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  assign key_match  = (bus.keyDigit == exp_digit);
  assign last_digit = (digit_idx == (lvl_lat - LVL_W'(1)));

  assign timer_en    = (state == ST_LISTEN);
  assign timer_clear = (state != ST_LISTEN) || bus.keyValid;

  input_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      seq_lat   <= '0;
      lvl_lat   <= LVL_W'(1);
      digit_idx <= '0;
      fail_code <= FAIL_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            seq_lat   <= bus.seq;
            lvl_lat   <= clamp_lvl(bus.curLvl);
            digit_idx <= '0;
            fail_code <= FAIL_NONE;
            state     <= ST_LISTEN;
          end
        end
        ST_LISTEN: begin
          // A key arriving on the expiry cycle takes priority over the timeout.
          if (bus.keyValid) begin
            if (!key_match) begin
              fail_code <= FAIL_WRONG;
              state     <= ST_FAIL;
            end else if (last_digit) begin
              state     <= ST_PASS;
            end else begin
              digit_idx <= digit_idx + IDX_W'(1);
            end
          end else if (timer_expired) begin
            fail_code <= FAIL_TIMEOUT;
            state     <= ST_FAIL;
          end
        end
        ST_PASS: state <= ST_IDLE;
        ST_FAIL: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.listening = (state == ST_LISTEN);
  assign bus.lvlPass   = (state == ST_PASS);
  assign bus.lvlFail   = (state == ST_FAIL);
  assign bus.digitIdx  = digit_idx;
  assign bus.failCode  = fail_code;

endmodule

// File: tb/tb_check_input_seq.sv
// Directed scenarios plus randomized traffic for check_input_seq, checked every cycle
// against a round-level reference model of the player-response rules.
module tb_check_input_seq;
  import game_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  check_input_seq_if bus ();

  check_input_seq #(
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit m_listen = 1'b0;
  bit m_pass   = 1'b0;
  bit m_fail   = 1'b0;
  int m_idx    = 0;
  int m_lvl    = 1;
  int m_wait   = 0;
  int m_code   = 0;
  int m_digits [NUM_DIGITS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit was_pulse;
    was_pulse = m_pass || m_fail;
    m_pass = 1'b0;
    m_fail = 1'b0;
    if (!rst) begin
      m_listen = 1'b0;
      m_idx    = 0;
      m_code   = 0;
      m_wait   = 0;
    end else if (m_listen) begin
      if (bus.keyValid) begin
        if (int'(bus.keyDigit) == m_digits[m_idx]) begin
          if (m_idx + 1 == m_lvl) begin
            m_pass   = 1'b1;
            m_listen = 1'b0;
          end else begin
            m_idx++;
            m_wait = 0;
          end
        end else begin
          m_code   = 1;
          m_fail   = 1'b1;
          m_listen = 1'b0;
        end
      end else if (m_wait == TO - 1) begin
        m_code   = 2;
        m_fail   = 1'b1;
        m_listen = 1'b0;
      end else begin
        m_wait++;
      end
    end else if (!was_pulse && bus.start) begin
      if (bus.curLvl == 0)
        m_lvl = 1;
      else if (int'(bus.curLvl) > NUM_DIGITS)
        m_lvl = NUM_DIGITS;
      else
        m_lvl = int'(bus.curLvl);
      for (int i = 0; i < NUM_DIGITS; i++)
        m_digits[i] = int'((bus.seq >> (DIGIT_W * (NUM_DIGITS - 1 - i))) & 20'hF);
      m_idx    = 0;
      m_code   = 0;
      m_wait   = 0;
      m_listen = 1'b1;
    end
  endtask

  task automatic compare_all();
    chk("listening", 32'(bus.listening), 32'(m_listen));
    chk("digitIdx",  32'(bus.digitIdx),  32'(m_idx));
    chk("lvlPass",   32'(bus.lvlPass),   32'(m_pass));
    chk("lvlFail",   32'(bus.lvlFail),   32'(m_fail));
    chk("failCode",  32'(bus.failCode),  32'(m_code));
  endtask

  task automatic drive(input bit st, input bit kv, input logic [3:0] kd);
    bus.start    = st;
    bus.keyValid = kv;
    bus.keyDigit = kd;
    @(posedge clk);
    model_step();
    #2;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 4'($urandom));
  endtask

  task automatic key(input logic [3:0] d);
    drive(1'b0, 1'b1, d);
  endtask

  task automatic begin_round(input logic [19:0] s, input logic [2:0] lvl);
    bus.seq    = s;
    bus.curLvl = lvl;
    drive(1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    bit kv;
    bit st;
    logic [3:0] kd;
    int key_odds;

    bus.start    = 1'b0;
    bus.keyValid = 1'b0;
    bus.keyDigit = '0;
    bus.seq      = '0;
    bus.curLvl   = '0;
    rst          = 1'b0;
    idle(2);
    chk("rst_listening", 32'(bus.listening), 32'd0);
    chk("rst_failCode",  32'(bus.failCode),  32'd0);
    rst = 1'b1;
    idle(2);

    // 1: correct three-digit entry, then start during the pass pulse is ignored
    begin_round(20'h31402, 3'd3);
    idle(2); key(4'd3);
    idle(2); key(4'd1);
    idle(2); key(4'd4);
    chk("s1_pass",     32'(bus.lvlPass),  32'd1);
    chk("s1_failCode", 32'(bus.failCode), 32'd0);
    chk("s1_digitIdx", 32'(bus.digitIdx), 32'd2);
    drive(1'b1, 1'b0, 4'd0);
    chk("s1_start_in_pulse", 32'(bus.listening), 32'd0);
    idle(2);

    // 2: wrong second digit
    begin_round(20'h31402, 3'd3);
    key(4'd3);
    key(4'd2);
    chk("s2_fail",     32'(bus.lvlFail),  32'd1);
    chk("s2_nopass",   32'(bus.lvlPass),  32'd0);
    chk("s2_failCode", 32'(bus.failCode), 32'd1);
    idle(2);

    // 3: timeout with no keys, then timer restart after a key
    begin_round(20'h31402, 3'd3);
    idle(15);
    chk("s3_not_yet", 32'(bus.lvlFail), 32'd0);
    idle(1);
    chk("s3_timeout", 32'(bus.lvlFail),  32'd1);
    chk("s3_code",    32'(bus.failCode), 32'd2);
    idle(2);
    begin_round(20'h31402, 3'd3);
    idle(9); key(4'd3);
    idle(15);
    chk("s3b_not_yet", 32'(bus.lvlFail), 32'd0);
    idle(1);
    chk("s3b_timeout", 32'(bus.lvlFail), 32'd1);
    idle(2);

    // 4: level clamping
    begin_round(20'h31402, 3'd0);
    key(4'd3);
    chk("s4_lvl0_pass", 32'(bus.lvlPass), 32'd1);
    idle(1);
    begin_round(20'h31402, 3'd7);
    key(4'd3); key(4'd1); key(4'd4); key(4'd0);
    chk("s4_lvl7_mid", 32'(bus.lvlPass), 32'd0);
    key(4'd2);
    chk("s4_lvl7_pass", 32'(bus.lvlPass),  32'd1);
    chk("s4_lvl7_idx",  32'(bus.digitIdx), 32'd4);
    idle(1);

    // 5: key on the expiry cycle wins
    begin_round(20'h31402, 3'd1);
    idle(15);
    key(4'd3);
    chk("s5_pass",   32'(bus.lvlPass), 32'd1);
    chk("s5_nofail", 32'(bus.lvlFail), 32'd0);
    idle(1);

    // 6: reset mid-round, key in idle ignored, fresh round
    begin_round(20'h31402, 3'd3);
    key(4'd3); key(4'd1);
    rst = 1'b0;
    idle(1);
    chk("s6_listening", 32'(bus.listening), 32'd0);
    chk("s6_idx",       32'(bus.digitIdx),  32'd0);
    rst = 1'b1;
    idle(1);
    key(4'd3);
    chk("s6_idle_key", 32'(bus.listening), 32'd0);
    drive(1'b1, 1'b1, 4'd3);
    chk("s6_start_key_idx", 32'(bus.digitIdx), 32'd0);
    key(4'd3); key(4'd1); key(4'd4);
    chk("s6_pass", 32'(bus.lvlPass), 32'd1);
    idle(1);

    // randomized traffic; sparse-key blocks exercise timeouts
    key_odds = 3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0)
        key_odds = ($urandom_range(0, 1) == 0) ? 3 : 40;
      bus.seq    = 20'($urandom);
      bus.curLvl = 3'($urandom);
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      st  = ($urandom_range(0, 3) == 0);
      kv  = ($urandom_range(0, key_odds - 1) == 0);
      if (m_listen && $urandom_range(0, 4) != 0)
        kd = 4'(m_digits[m_idx]);
      else
        kd = 4'($urandom);
      drive(st, kv, kd);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
